// File: rtl/tdes_mode_engine_if.sv
// Streaming and DES-core handshake bundle for tdes_mode_engine.
// slave is the engine's view; master is the source/sink and core side.
interface tdes_mode_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        core_start;
  logic        core_decrypt;
  logic [63:0] core_key;
  logic [63:0] core_din;
  logic [63:0] core_dout;
  logic        core_done;

  modport slave (
    input  in_valid, in_data, out_ready, core_dout, core_done,
    output in_ready, out_valid, out_data, core_start, core_decrypt, core_key, core_din
  );

  modport master (
    output in_valid, in_data, out_ready, core_dout, core_done,
    input  in_ready, out_valid, out_data, core_start, core_decrypt, core_key, core_din
  );
endinterface

// File: rtl/tdes_mode_engine.sv
// Triple-DES ECB/CBC sequencer driving one external single-DES core.
// Optional core watchdog enabled by defining TDES_TIMEOUT_EN (TIMEOUT_CYCLES >= 2).
module tdes_mode_engine #(
  parameter int unsigned KEYING         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         key1,
  input  logic [63:0]         key2,
  input  logic [63:0]         key3,
  input  logic                decrypt,
  input  logic                cbc_en,
  input  logic                iv_load,
  input  logic [63:0]         iv,
  tdes_mode_engine_if.slave   bus,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOutput} state_e;

  localparam logic [1:0] LastPass = (KEYING == 1) ? 2'd0 : 2'd2;

  state_e      state_q, state_d;
  logic [1:0]  pass_q, pass_d;
  logic [63:0] blk_q, blk_d;
  logic [63:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [63:0] chain_q, chain_d;
  logic [63:0] work_q, work_d;
  logic [63:0] out_q, out_d;
  logic        dec_q, dec_d, cbc_q, cbc_d, err_q, err_d;
  logic        timeout;
  logic [63:0] k3_eff, chain_mask, pass_key, pass_din, final_out;
  logic        pass_dir;

`ifdef TDES_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TimerW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (state_q == StIssue) begin
      timer_d = '0;
    end else if (state_q == StWait) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Fires so that err rises exactly TIMEOUT_CYCLES cycles after the start pulse.
  assign timeout = (state_q == StWait) && !bus.core_done &&
                   (timer_q == TimerW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign k3_eff     = (KEYING == 2) ? k1_q : k3_q;
  assign chain_mask = cbc_q ? chain_q : 64'h0;

  // Encrypt runs E(k1) D(k2) E(k3); decrypt runs D(k3) E(k2) D(k1).
  always_comb begin
    pass_key = k1_q;
    pass_dir = dec_q;
    case (pass_q)
      2'd0: pass_key = (dec_q && (KEYING != 1)) ? k3_eff : k1_q;
      2'd1: begin
        pass_key = k2_q;
        pass_dir = !dec_q;
      end
      2'd2: pass_key = dec_q ? k1_q : k3_eff;
      default: ;
    endcase
  end

  assign pass_din  = (pass_q != 2'd0) ? work_q : (dec_q ? blk_q : (blk_q ^ chain_mask));
  assign final_out = dec_q ? (bus.core_dout ^ chain_mask) : bus.core_dout;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    blk_d   = blk_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    k3_d    = k3_q;
    dec_d   = dec_q;
    cbc_d   = cbc_q;
    chain_d = chain_q;
    work_d  = work_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (iv_load) begin
          chain_d = iv;
        end else if (bus.in_valid) begin
          blk_d   = bus.in_data;
          k1_d    = key1;
          k2_d    = key2;
          k3_d    = key3;
          dec_d   = decrypt;
          cbc_d   = cbc_en;
          pass_d  = 2'd0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.core_done) begin
          work_d = bus.core_dout;
          if (pass_q == LastPass) begin
            out_d = final_out;
            if (cbc_q) begin
              chain_d = dec_q ? blk_q : bus.core_dout;
            end
            state_d = StOutput;
          end else begin
            pass_d  = pass_q + 2'd1;
            state_d = StIssue;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StOutput: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pass_q  <= 2'd0;
      blk_q   <= 64'h0;
      k1_q    <= 64'h0;
      k2_q    <= 64'h0;
      k3_q    <= 64'h0;
      dec_q   <= 1'b0;
      cbc_q   <= 1'b0;
      chain_q <= 64'h0;
      work_q  <= 64'h0;
      out_q   <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      blk_q   <= blk_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      dec_q   <= dec_d;
      cbc_q   <= cbc_d;
      chain_q <= chain_d;
      work_q  <= work_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // in_ready stays low while reset is asserted.
  assign bus.in_ready     = (state_q == StIdle) && reset && !iv_load;
  assign bus.out_valid    = (state_q == StOutput);
  assign bus.out_data     = out_q;
  assign bus.core_start   = (state_q == StIssue);
  assign bus.core_decrypt = pass_dir;
  assign bus.core_key     = pass_key;
  assign bus.core_din     = pass_din;
  assign busy             = (state_q != StIdle);
  assign err              = err_q;

endmodule

// File: tb/tb_tdes_mode_engine.sv
// Randomized self-checking bench for tdes_mode_engine with a toy invertible core model.
module tb_tdes_mode_engine;
  localparam logic [63:0] KE       = 64'hAABB09182736CCDD;
  localparam logic [63:0] KA       = 64'h0123456789ABCDEF;
  localparam logic [63:0] KB       = 64'h23456789ABCDEF01;
  localparam logic [63:0] KC       = 64'h456789ABCDEF0123;
  localparam logic [63:0] PT       = 64'h123456ABCD132536;
  // Toy core: E(k,x) = rotl8(x) ^ k, D(k,y) = rotr8(y ^ k); equal keys give E(KE, PT).
  localparam logic [63:0] CT       = 64'h9EEDA2D53413FACF;
  localparam logic [63:0] CBC2_DIN = 64'h8CD9F47EF900DFF9;

  typedef struct packed {
    logic        dir;
    logic [63:0] key;
    logic [63:0] din;
    logic        first;
    logic        last;
  } pass_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] key1 = '0, key2 = '0, key3 = '0, iv = '0;
  logic        decrypt = 1'b0, cbc_en = 1'b0, iv_load = 1'b0;
  logic        busy, err;

  tdes_mode_engine_if bus ();

  tdes_mode_engine #(.KEYING(3), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .key1    (key1),
    .key2    (key2),
    .key3    (key3),
    .decrypt (decrypt),
    .cbc_en  (cbc_en),
    .iv_load (iv_load),
    .iv      (iv),
    .bus     (bus),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [63:0] chain_m = '0;
  pass_t       pq[$];
  logic [63:0] oq[$];
  logic [63:0] last_out = '0, last_din1 = '0;
  int          or_mode = 0;
  int          n_starts = 0;
  int          hold_from = 32'h7fffffff;
  logic        spurious = 1'b0;
  logic        pend = 1'b0, c_live = 1'b0, c_dir = 1'b0;
  int          cnt = 0;
  logic [63:0] c_key = '0, c_din = '0, c_res = '0;
  logic        final_armed = 1'b0, ov_due = 1'b0, prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  function automatic logic [63:0] e1(input logic [63:0] k, input logic [63:0] x);
    return {x[55:0], x[63:56]} ^ k;
  endfunction

  function automatic logic [63:0] d1(input logic [63:0] k, input logic [63:0] y);
    logic [63:0] t;
    t = y ^ k;
    return {t[7:0], t[63:8]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Random backpressure unless forced low (1) or high (2).
  always @(posedge clk) begin
    #1;
    bus.out_ready = (or_mode == 0) ? ($urandom_range(0, 2) != 0) : (or_mode == 2);
  end

  // Core model: capture on start, answer after a random delay unless withheld.
  always @(negedge clk) begin
    if (!reset) begin
      pend   = 1'b0;
      c_live = 1'b0;
    end else begin
      if (c_live && bus.core_done) begin
        check("core_key_hold", bus.core_key, c_key);
        check("core_din_hold", bus.core_din, c_din);
        check("core_dir_hold", bus.core_decrypt, c_dir);
        c_live = 1'b0;
      end
      if (bus.core_start) begin
        n_starts++;
        pend   = 1'b1;
        c_live = 1'b1;
        cnt    = $urandom_range(0, 4);
        c_key  = bus.core_key;
        c_din  = bus.core_din;
        c_dir  = bus.core_decrypt;
        c_res  = c_dir ? d1(c_key, c_din) : e1(c_key, c_din);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.core_done = 1'b0;
    if (pend && reset) begin
      if (cnt == 0) begin
        if (n_starts < hold_from) begin
          bus.core_done = 1'b1;
          bus.core_dout = c_res;
          pend          = 1'b0;
        end
      end else begin
        cnt--;
      end
    end else if (spurious) begin
      bus.core_done = 1'b1;
      bus.core_dout = {$urandom, $urandom};
      spurious      = 1'b0;
    end
  end

  // Compare process: pass schedule, output data, latency and handshake rules.
  always @(negedge clk) begin
    pass_t p;
    if (!reset) begin
      pq.delete();
      oq.delete();
      final_armed = 1'b0;
      ov_due      = 1'b0;
      prev_hold   = 1'b0;
    end else begin
      if (busy) check("in_ready_busy", bus.in_ready, 0);
      if (prev_hold) begin
        check("out_valid_hold", bus.out_valid, 1);
        check("out_data_hold", bus.out_data, prev_data);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (ov_due) begin
        check("out_valid_latency", bus.out_valid, 1);
        ov_due = 1'b0;
      end
      if (bus.core_start) begin
        if (pq.size() == 0) begin
          fail_bound("core_start_unexpected");
        end else begin
          p = pq.pop_front();
          check("core_key", bus.core_key, p.key);
          check("core_decrypt", bus.core_decrypt, p.dir);
          check("core_din", bus.core_din, p.din);
          if (p.first) last_din1 = bus.core_din;
          if (p.last) final_armed = 1'b1;
        end
      end
      if (bus.core_done && final_armed) begin
        check("out_valid_early", bus.out_valid, 0);
        ov_due      = 1'b1;
        final_armed = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (oq.size() == 0) begin
          fail_bound("out_unexpected");
        end else begin
          check("out_data", bus.out_data, oq.pop_front());
          last_out = bus.out_data;
        end
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic dc, input logic cb,
                      input logic [63:0] ka, input logic [63:0] kb, input logic [63:0] kc);
    logic [63:0] ks[3];
    logic [63:0] v, o;
    logic        dr;
    int          g;
    @(posedge clk);
    #1;
    bus.in_data  = d;
    decrypt      = dc;
    cbc_en       = cb;
    key1         = ka;
    key2         = kb;
    key3         = kc;
    bus.in_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.in_ready && g < 1000);
    if (!bus.in_ready) begin
      fail_bound("accept");
      bus.in_valid = 1'b0;
      return;
    end
    ks[0] = dc ? kc : ka;
    ks[1] = kb;
    ks[2] = dc ? ka : kc;
    v = dc ? d : (d ^ (cb ? chain_m : 64'h0));
    for (int i = 0; i < 3; i++) begin
      dr = (i == 1) ? !dc : dc;
      pq.push_back('{dir: dr, key: ks[i], din: v, first: (i == 0), last: (i == 2)});
      v = dr ? d1(ks[i], v) : e1(ks[i], v);
    end
    o = dc ? (v ^ (cb ? chain_m : 64'h0)) : v;
    if (cb) chain_m = dc ? d : o;
    oq.push_back(o);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    key1         = {$urandom, $urandom};
    key2         = {$urandom, $urandom};
    key3         = {$urandom, $urandom};
    decrypt      = 1'($urandom_range(0, 1));
    cbc_en       = 1'($urandom_range(0, 1));
  endtask

  task automatic load_iv(input logic [63:0] v, input logic wv, input logic idle_exp);
    @(posedge clk);
    #1;
    iv_load      = 1'b1;
    iv           = v;
    bus.in_valid = wv;
    bus.in_data  = {$urandom, $urandom};
    @(negedge clk);
    if (idle_exp) begin
      check("in_ready_ivload", bus.in_ready, 0);
      chain_m = v;
    end else begin
      check("busy_at_ivload", busy, 1);
    end
    @(posedge clk);
    #1;
    iv_load      = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy || oq.size() != 0) && g < 2000);
    if (busy || oq.size() != 0) fail_bound("wait_idle");
  endtask

  initial begin
    logic [63:0] c1, c2, held;
    int          g, seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.core_done = 1'b0;
    bus.core_dout = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_core_start", bus.core_start, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);

    // ECB known answers and distinct-key round trip
    send(PT, 1'b0, 1'b0, KE, KE, KE);
    wait_idle();
    check("ecb_enc_literal", last_out, CT);
    send(CT, 1'b1, 1'b0, KE, KE, KE);
    wait_idle();
    check("ecb_dec_literal", last_out, PT);
    send(PT, 1'b0, 1'b0, KA, KB, KC);
    wait_idle();
    held = last_out;
    send(held, 1'b1, 1'b0, KA, KB, KC);
    wait_idle();
    check("ecb_roundtrip", last_out, PT);

    // CBC chaining, IV load takes priority over a pending block
    load_iv(64'h0, 1'b1, 1'b1);
    send(PT, 1'b0, 1'b1, KE, KE, KE);
    wait_idle();
    check("cbc_blk1_literal", last_out, CT);
    c1 = last_out;
    send(PT, 1'b0, 1'b1, KE, KE, KE);
    wait_idle();
    check("cbc_blk2_din_literal", last_din1, CBC2_DIN);
    c2 = last_out;
    load_iv(64'h0, 1'b0, 1'b1);
    send(c1, 1'b1, 1'b1, KE, KE, KE);
    wait_idle();
    check("cbc_dec_blk1", last_out, PT);
    send(c2, 1'b1, 1'b1, KE, KE, KE);
    wait_idle();
    check("cbc_dec_blk2", last_out, PT);

    // Output stall and iv_load while busy
    or_mode = 1;
    send({$urandom, $urandom}, 1'b0, 1'b1, KA, KB, KC);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.out_valid && g < 200);
    if (!bus.out_valid) fail_bound("stall_out_valid");
    held = bus.out_data;
    load_iv({$urandom, $urandom}, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", bus.out_data, held);
      check("stall_in_ready", bus.in_ready, 0);
    end
    or_mode = 2;
    wait_idle();
    or_mode = 0;
    send({$urandom, $urandom}, 1'b0, 1'b1, KA, KB, KC);
    wait_idle();

    // Reset during pass 2 wait, then a stale core_done
    hold_from = n_starts + 2;
    send(PT, 1'b0, 1'b0, KE, KE, KE);
    seen = 0;
    g = 0;
    while (seen < 2 && g < 200) begin
      if (g > 0 || seen > 0) @(negedge clk);
      else @(negedge clk);
      if (bus.core_start) seen++;
      g++;
    end
    if (seen < 2) fail_bound("reset_pass2_start");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_core_start", bus.core_start, 0);
    check("midrst_core_key", bus.core_key, 0);
    check("midrst_core_din", bus.core_din, 0);
    check("midrst_core_decrypt", bus.core_decrypt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    chain_m   = '0;
    hold_from = 32'h7fffffff;
    @(posedge clk);
    #3 reset = 1'b1;
    spurious = 1'b1;
    repeat (4) @(negedge clk);
    check("stale_done_busy", busy, 0);
    check("stale_done_out_valid", bus.out_valid, 0);
    send(PT, 1'b0, 1'b0, KE, KE, KE);
    wait_idle();
    check("after_reset_literal", last_out, CT);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        wait_idle();
        load_iv({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      end
      if ($urandom_range(0, 3) == 0) begin
        held = {$urandom, $urandom};
        send({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             held, {$urandom, $urandom}, held);
      end else begin
        send({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      end
    end
    wait_idle();

    // Core never answers
    hold_from = n_starts + 1;
    send(PT, 1'b0, 1'b0, KE, KE, KE);
    @(negedge clk);
    check("hang_start", bus.core_start, 1);
`ifdef TDES_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("timeout_err_before", err, 0);
    @(negedge clk);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("timeout_no_out_valid", bus.out_valid, 0);
    check("timeout_err_sticky", err, 1);
`else
    repeat (40) @(negedge clk);
    check("hang_busy", busy, 1);
    check("hang_err", err, 0);
`endif
    hold_from = 32'h7fffffff;
    @(posedge clk);
    #1 reset = 1'b0;
    chain_m = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("final_err_cleared", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end
endmodule
